// File: rtl/audio_clk_gen_if.sv
// Control/status bundle for audio_clk_gen: lock and rate requests in, ready and audio clocks out.
interface audio_clk_gen_if #(
  parameter int CHANNELS = 2,
  parameter int FREQ_W   = 20
);
  logic                         I_lock;
  logic [CHANNELS*FREQ_W-1:0]   I_freq;
  logic                         O_ready;
  logic [CHANNELS-1:0]          O_clk_audio;
  logic [CHANNELS-1:0]          O_tick;

  modport master (output I_lock, I_freq, input O_ready, O_clk_audio, O_tick);
  modport slave  (input I_lock, I_freq, output O_ready, O_clk_audio, O_tick);
endinterface

// File: rtl/audio_clk_gen.sv
// Lock-qualified multi-channel fractional audio clock generator.
// Each channel is a Bresenham accumulator giving exact long-term rate from the pixel clock.
module audio_clk_chan #(
  parameter int CLK_HZ = 27000000,
  parameter int FREQ_W = 20
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [FREQ_W-1:0] freq,
  output logic              clk_audio,
  output logic              tick
);
  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int SUM_W = ((FREQ_W > ACC_W) ? FREQ_W : ACC_W) + 2;
  localparam int FMAX  = (CLK_HZ - 1) / 2;

  localparam logic [ACC_W-1:0] CLK_LIM = ACC_W'(CLK_HZ);
  localparam logic [SUM_W-1:0] FMAX_X  = SUM_W'(FMAX);
  localparam logic [ACC_W-1:0] FMAX_Q  = ACC_W'(FMAX);

  logic [ACC_W-1:0] acc, sum, freq_q, freq_c;
  logic [SUM_W-1:0] freq_x;
  logic             wrap, rise;

  always_comb begin
    sum    = acc + {freq_q[ACC_W-2:0], 1'b0};
    wrap   = (sum >= CLK_LIM);
    rise   = wrap && !clk_audio;
    freq_x = SUM_W'(freq);
    freq_c = (freq_x > FMAX_X) ? FMAX_Q : ACC_W'(freq_x);
  end

  // The rate reloads on the edge that raises the clock, so a new rate
  // governs the whole period that starts with the tick.
  always_ff @(posedge clk) begin
    if (clear) begin
      acc       <= '0;
      freq_q    <= '0;
      clk_audio <= 1'b0;
      tick      <= 1'b0;
    end else begin
      acc       <= wrap ? (sum - CLK_LIM) : sum;
      clk_audio <= clk_audio ^ wrap;
      tick      <= rise;
      if (freq_q == '0 || rise)
        freq_q <= freq_c;
    end
  end
endmodule

module audio_clk_gen #(
  parameter int CLK_HZ      = 27000000,
  parameter int CHANNELS    = 2,
  parameter int FREQ_W      = 20,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic            I_clk,
  input  logic            I_reset,
  audio_clk_gen_if.slave  bus
);
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic [CNT_W-1:0]    lock_cnt;
  logic                ready, clear;
  logic [CHANNELS-1:0] clk_audio, tick;

  // Ready rises on the edge that samples the LOCK_CYCLES-th consecutive lock.
  always_ff @(posedge I_clk) begin
    if (I_reset || !bus.I_lock) begin
      lock_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      if (lock_cnt != CNT_W'(LOCK_CYCLES))
        lock_cnt <= lock_cnt + CNT_W'(1);
      if (lock_cnt >= CNT_W'(LOCK_CYCLES - 1))
        ready <= 1'b1;
    end
  end

  assign clear = I_reset || !bus.I_lock || !ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    audio_clk_chan #(
      .CLK_HZ (CLK_HZ),
      .FREQ_W (FREQ_W)
    ) u_chan (
      .clk       (I_clk),
      .clear     (clear),
      .freq      (bus.I_freq[k*FREQ_W +: FREQ_W]),
      .clk_audio (clk_audio[k]),
      .tick      (tick[k])
    );
  end

  assign bus.O_ready     = ready;
  assign bus.O_clk_audio = clk_audio;
  assign bus.O_tick      = tick;
endmodule

// File: tb/tb_audio_clk_gen.sv
// Scoreboarded bench for audio_clk_gen: cycle model feeds a queue, monitor pops and compares.
module tb_audio_clk_gen;
  localparam int CLK_HZ = 1000;
  localparam int CH     = 2;
  localparam int FW     = 20;
  localparam int LC     = 8;
  localparam int FMAX   = (CLK_HZ - 1) / 2;

  typedef struct {
    bit          rdy;
    bit [CH-1:0] ck;
    bit [CH-1:0] tk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t sb[$];

  audio_clk_gen_if #(.CHANNELS(CH), .FREQ_W(FW)) bus();

  audio_clk_gen #(
    .CLK_HZ      (CLK_HZ),
    .CHANNELS    (CH),
    .FREQ_W      (FW),
    .LOCK_CYCLES (LC)
  ) dut (
    .I_clk   (clk),
    .I_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model state
  int m_cnt = 0;
  bit m_rdy = 0;
  int m_acc[CH], m_fq[CH];
  bit m_clk[CH], m_tick[CH];

  task automatic model_edge();
    bit was_rdy;
    int n, w, f;
    was_rdy = m_rdy;
    if (rst || !bus.I_lock) begin
      m_cnt = 0;
      m_rdy = 0;
    end else begin
      m_cnt = (m_cnt < LC) ? m_cnt + 1 : LC;
      m_rdy = (m_cnt >= LC);
    end
    for (int k = 0; k < CH; k++) begin
      if (rst || !bus.I_lock || !was_rdy) begin
        m_acc[k] = 0; m_fq[k] = 0; m_clk[k] = 0; m_tick[k] = 0;
      end else begin
        n = m_acc[k] + 2 * m_fq[k];
        w = n / CLK_HZ;
        m_acc[k] = n % CLK_HZ;
        m_tick[k] = (w == 1) && !m_clk[k];
        if (m_fq[k] == 0 || m_tick[k]) begin
          f = int'(bus.I_freq[k*FW +: FW]);
          m_fq[k] = (f > FMAX) ? FMAX : f;
        end
        if (w == 1) m_clk[k] = !m_clk[k];
      end
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      #4;
      chk("sb_ready", int'(bus.O_ready), int'(e.rdy));
      chk("sb_clk", int'(bus.O_clk_audio), int'(e.ck));
      chk("sb_tick", int'(bus.O_tick), int'(e.tk));
    end
  end

  // observation statistics
  int first_tk[CH], last_tk[CH], ivl[CH], imin[CH], imax[CH], ntk[CH], ntog[CH];
  bit pclk[CH];
  bit ptk0 = 0;
  int dbl = 0;

  task automatic clr_stats();
    for (int k = 0; k < CH; k++) begin
      first_tk[k] = -1; last_tk[k] = -1; ivl[k] = -1;
      imin[k] = 1 << 30; imax[k] = -1; ntk[k] = 0; ntog[k] = 0;
      pclk[k] = bus.O_clk_audio[k];
    end
    ptk0 = bus.O_tick[0];
    dbl  = 0;
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e.rdy = m_rdy;
    for (int k = 0; k < CH; k++) begin
      e.ck[k] = m_clk[k];
      e.tk[k] = m_tick[k];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < CH; k++) begin
      if (bus.O_clk_audio[k] != pclk[k]) ntog[k]++;
      pclk[k] = bus.O_clk_audio[k];
      if (bus.O_tick[k]) begin
        ntk[k]++;
        if (first_tk[k] < 0) first_tk[k] = cyc;
        if (last_tk[k] >= 0) begin
          ivl[k]  = cyc - last_tk[k];
          imin[k] = (ivl[k] < imin[k]) ? ivl[k] : imin[k];
          imax[k] = (ivl[k] > imax[k]) ? ivl[k] : imax[k];
        end
        last_tk[k] = cyc;
      end
    end
    if (bus.O_tick[0] && ptk0) dbl++;
    ptk0 = bus.O_tick[0];
  endtask

  task automatic wait_ready(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (bus.O_ready) begin n = i; break; end
    end
  endtask

  task automatic wait_tick(input int ch, input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (bus.O_tick[ch]) begin n = i; break; end
    end
  endtask

  initial begin
    int n, c0;
    bus.I_lock = 1'b1;
    bus.I_freq = {20'd48, 20'd100};
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();
    chk("rst_state", int'({bus.O_ready, bus.O_clk_audio, bus.O_tick}), 0);

    // bring-up: ready after 8 locked edges, load on the 9th, ticks 5 (ch0) / 11 (ch1) later
    rst = 1'b0;
    c0 = cyc;
    clr_stats();
    wait_ready(20, n);
    chk("ready_lat", n, LC);
    while (cyc < c0 + 30) step();
    chk("first_tick0", first_tk[0] - c0, 14);
    chk("first_tick1", first_tk[1] - c0, 20);
    chk("period0", ivl[0], 10);

    // 48 Hz: exactly 48 ticks per 1000-cycle window, periods of 20 or 21
    while (cyc < c0 + 100) step();
    clr_stats();
    repeat (CLK_HZ) step();
    chk("win48", ntk[1], 48);
    chk("ivl48_min", imin[1], 20);
    chk("ivl48_max", imax[1], 21);

    // rate change mid-period: old period finishes, next period is 4 cycles
    wait_tick(0, 20, n);
    repeat (3) step();
    bus.I_freq[FW-1:0] = 20'd250;
    wait_tick(0, 20, n);
    chk("old_period", n, 7);
    wait_tick(0, 20, n);
    chk("new_period", n, 4);
    wait_tick(0, 20, n);
    chk("new_period2", n, 4);

    // over-range request clamps to FMAX
    bus.I_freq[FW-1:0] = 20'd700;
    wait_tick(0, 10, n);
    chk("clamp_load", int'(n > 0), 1);
    clr_stats();
    repeat (CLK_HZ) step();
    chk("clamp_tog", ntog[0], 2 * FMAX);
    chk("clamp_nodbl", dbl, 0);

    // one-cycle lock loss, then restart with the original latency
    bus.I_freq[FW-1:0] = 20'd100;
    bus.I_lock = 1'b0;
    step();
    chk("drop_ready", int'(bus.O_ready), 0);
    chk("drop_out", int'({bus.O_clk_audio, bus.O_tick}), 0);
    bus.I_lock = 1'b1;
    c0 = cyc;
    clr_stats();
    wait_ready(20, n);
    chk("relock_lat", n, LC);
    while (cyc < c0 + 30) step();
    chk("relock_tick0", first_tk[0] - c0, 14);

    // zero request while running freezes the clock high after the next tick
    bus.I_freq[2*FW-1:FW] = 20'd0;
    wait_tick(1, 40, n);
    chk("zero_tick_seen", int'(n > 0), 1);
    clr_stats();
    repeat (50) step();
    chk("freeze_hi", int'(bus.O_clk_audio[1]), 1);
    chk("freeze_tog", ntog[1], 0);

    // reset mid-run, then ready with zero rates gives no activity
    bus.I_freq = '0;
    rst = 1'b1;
    step();
    chk("midrst_ready", int'(bus.O_ready), 0);
    chk("midrst_out", int'({bus.O_clk_audio, bus.O_tick}), 0);
    rst = 1'b0;
    clr_stats();
    wait_ready(20, n);
    chk("midrst_lat", n, LC);
    repeat (100) step();
    chk("zero_ticks", ntk[0] + ntk[1], 0);
    chk("zero_clk", int'(bus.O_clk_audio), 0);

    @(posedge clk);
    #6;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
